// File: rtl/bcd_seg7_scan.sv
// ============================================================================
//  Module   : bcd_seg7_scan
//  Purpose  : Six-digit multiplexed 7-segment driver for BCD digits with
//             leading-zero blanking, per-digit DP, dead-time and frame-aligned
//             display updates.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg7_scan #(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 2,
    parameter int LZ_BLANK = 1,
    parameter int ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d5,
    input  logic [3:0] d4,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [5:0] dp_sel,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame
);

    localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  DEAD      = CW'(DEAD_CYC);
    localparam logic           POL       = (ACT_LOW != 0);
    localparam logic           LZ_EN     = (LZ_BLANK != 0);

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h40;
        endcase
    endfunction

    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    idx_q,     idx_d;
    logic [23:0]   pend_q,    pend_d;
    logic [5:0]    pend_dp_q, pend_dp_d;
    logic          pend_v_q,  pend_v_d;
    logic [23:0]   disp_q,    disp_d;
    logic [5:0]    disp_dp_q, disp_dp_d;
    logic [5:0]    an_q,      an_d;
    logic [6:0]    seg_q,     seg_d;
    logic          dp_q,      dp_d;
    logic          frame_q,   frame_d;

    logic [23:0]   din;
    logic          cnt_last;
    logic          at_bound;
    logic [5:0]    lz;
    logic [3:0]    sel_dig;
    logic          sel_lz;
    logic          sel_dp;

    assign din      = {d5, d4, d3, d2, d1, d0};
    assign cnt_last = (cnt_q == CNT_MAX);
    assign at_bound = cnt_last && (idx_q == 3'd5);

    // Digit k is blank when it and every more-significant digit are zero.
    assign lz[0] = 1'b0;
    generate
        for (genvar k = 1; k < 6; k++) begin : g_lz
            assign lz[k] = LZ_EN && (disp_q[23:4*k] == '0);
        end
    endgenerate

    always_comb begin
        sel_dig = 4'd0;
        sel_lz  = 1'b0;
        sel_dp  = 1'b0;
        case (idx_q)
            3'd0:    begin sel_dig = disp_q[3:0];   sel_lz = lz[0]; sel_dp = disp_dp_q[0]; end
            3'd1:    begin sel_dig = disp_q[7:4];   sel_lz = lz[1]; sel_dp = disp_dp_q[1]; end
            3'd2:    begin sel_dig = disp_q[11:8];  sel_lz = lz[2]; sel_dp = disp_dp_q[2]; end
            3'd3:    begin sel_dig = disp_q[15:12]; sel_lz = lz[3]; sel_dp = disp_dp_q[3]; end
            3'd4:    begin sel_dig = disp_q[19:16]; sel_lz = lz[4]; sel_dp = disp_dp_q[4]; end
            3'd5:    begin sel_dig = disp_q[23:20]; sel_lz = lz[5]; sel_dp = disp_dp_q[5]; end
            default: begin sel_dig = 4'd0;          sel_lz = 1'b1;  sel_dp = 1'b0;         end
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;

        if (cnt_last) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        // A load on the boundary bypasses the pending buffer so the newest data wins.
        if (load) begin
            if (at_bound) begin
                disp_d    = din;
                disp_dp_d = dp_sel;
                pend_v_d  = 1'b0;
            end else begin
                pend_d    = din;
                pend_dp_d = dp_sel;
                pend_v_d  = 1'b1;
            end
        end else if (at_bound && pend_v_q) begin
            disp_d    = pend_q;
            disp_dp_d = pend_dp_q;
            pend_v_d  = 1'b0;
        end

        an_d    = (!blank && (cnt_q >= DEAD)) ? (6'b000001 << idx_q) : 6'b000000;
        seg_d   = sel_lz ? 7'h00 : f_decode(sel_dig);
        dp_d    = sel_dp && !sel_lz;
        frame_d = at_bound;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            pend_v_q  <= 1'b0;
            disp_q    <= '0;
            disp_dp_q <= '0;
            an_q      <= {6{POL}};
            seg_q     <= {7{POL}};
            dp_q      <= POL;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            pend_v_q  <= pend_v_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            an_q      <= an_d  ^ {6{POL}};
            seg_q     <= seg_d ^ {7{POL}};
            dp_q      <= dp_d  ^ POL;
            frame_q   <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

`default_nettype wire
